ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand-forwarding and load-use hazard unit for the pipelined MIPS core.
//  Sits directly upstream of the ALU: captures decoded operands/controls, drives ALU a, b, sel, shamt.
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by stalling decode and inserting a bubble.
// PARAMETERS
//  DW      32  datapath width (ALU operand width)
//  RW      5   register-index width
//  CNTW    16  width of saturating stall counter
// PORTS
//  clk            in   1     rising-edge clock
//  reset_n        in   1     one clock; reset is asynchronous and active-low
//  id_valid       in   1     decode slot holds a real instruction
//  id_rs_val      in   DW    register-file read data, rs
//  id_rt_val      in   DW    register-file read data, rt
//  id_imm         in   DW    sign/zero-extended immediate
//  id_rs, id_rt   in   RW    source indices
//  id_rd          in   RW    destination index (already muxed rd/rt)
//  id_uses_rt     in   1     instruction reads rt (R-type, store, beq)
//  id_alusrc      in   1     1: ALU b = immediate
//  id_alu_sel     in   4     ALU function code
//  id_shamt       in   5     shift amount
//  id_regwrite, id_memread, id_memwrite, id_memtoreg  in 1 each  decode controls
//  flush          in   1     branch/jump taken: kill instruction entering EX
//  exmem_regwrite in   1 ; exmem_rd in RW ; exmem_result in DW   EX/MEM forward source
//  memwb_regwrite in   1 ; memwb_rd in RW ; memwb_result in DW   MEM/WB forward source
//  stall          out  1     hold PC and IF/ID this cycle (combinational)
//  alu_a, alu_b   out  DW    ALU operands (forward-muxed)
//  alu_sel        out  4 ; alu_shamt out 5   registered ALU controls
//  ex_store_data  out  DW    forwarded rt value for sw
//  ex_rd out RW ; ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg out 1 each
//  stall_count    out  CNTW  saturating count of bubble cycles
// BEHAVIOUR
//  - Reset: all registered outputs 0 (alu_sel=4'b0000, ex_valid=0, controls 0, stall_count=0); alu_a/alu_b=0.
//  - Latency: one clock ID->EX. Forward mux is combinational on the EX side of the register.
//  - load_use = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//  - stall = load_use. When stall: register loads a bubble (ex_valid=0, regwrite/memread/memwrite/memtoreg=0,
//    alu_sel=0); decode is held upstream; stall_count+1, saturating at all-ones.
//  - flush has priority over stall and normal capture: loads bubble; stall_count unchanged; stall still driven.
//  - Else capture: all id_* fields into registers, ex_valid=id_valid; id_valid=0 also clears write/mem controls.
//  - Forward for operand A (rs) and rt: EX/MEM match (regwrite & rd!=0 & rd==src) wins over MEM/WB match;
//    else registered register-file value. Register 0 never forwarded; value read as registered.
//  - alu_b = alusrc ? registered imm : forwarded rt. ex_store_data = forwarded rt always.
//  - Register file writes on falling edge; no WB-stage forward path needed here.
//  - Reset asserted mid-operation: immediate return to reset values, in-flight instruction discarded.
// CONFIGURATION
//  EX_FWD_EN defined: forwarding as above; only load-use stalls (exactly one bubble per load-use pair).
//  EX_FWD_EN undefined: no forward muxes (operands = registered values); stall whenever a valid
//    ID source matches ex_rd (ex_regwrite) or exmem_rd (exmem_regwrite), rd!=0; repeats until clear (up to 2).
// TESTING
//  1 add $3,$1,$2 then sub $4,$3,$1 back-to-back, exmem_result=0x10 -> alu_a=0x10, stall never 1 (EX_FWD_EN).
//  2 lw $5 then add $6,$5,$5 -> stall=1 one cycle, bubble ex_valid=0, stall_count=1, then alu_a=alu_b=memwb_result.
//  3 EX/MEM and MEM/WB both target $7 (0xAA vs 0xBB), consumer reads $7 -> alu_a=0xAA.
//  4 Writer to $0 with result 0xFFFF_FFFF, consumer reads $0 -> alu_a=0 (registered zero), no forward.
//  5 flush during load-use stall -> next cycle ex_valid=0, all controls 0, stall_count unchanged.
//  6 Without EX_FWD_EN: add $3 then add $4,$3,$3 -> stall 2 cycles, then alu_a=register-file value; 
//    reset_n low mid-stall -> outputs 0 asynchronously, stall_count=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ============================================================================
// ex_operand_stage
// ----------------------------------------------------------------------------
// This is the ID/EX pipeline register for the pipelined MIPS core. It also
// holds the operand-forwarding logic and the hazard unit. It sits directly in
// front of the ALU.
//
// Build option (macro EX_FWD_EN):
//   defined   : operands for rs/rt are forwarded from EX/MEM, or else from
//               MEM/WB. Only a load-use pair stalls, and it stalls for exactly
//               one bubble.
//   undefined : there are no forward muxes, so the operands are the registered
//               register-file values. Decode stalls whenever a valid source
//               matches the EX or EX/MEM destination. That can repeat for up
//               to two cycles.
//
// Ports:
//   i_clk, i_reset_n            clock; asynchronous active-low reset
//   i_id_*                      decoded instruction fields from the ID stage
//   i_flush                     a taken branch/jump kills the instruction entering EX
//   i_exmem_*, i_memwb_*        writeback candidates used for forwarding
//   o_stall                     holds the PC and IF/ID this cycle (combinational)
//   o_alu_a, o_alu_b            ALU operands after forwarding
//   o_alu_sel, o_alu_shamt      registered ALU controls
//   o_ex_store_data             forwarded rt value, used by stores
//   o_ex_rd, o_ex_valid, o_ex_regwrite, o_ex_memread, o_ex_memwrite,
//   o_ex_memtoreg               registered EX-stage controls
//   o_stall_count               saturating count of stall bubbles
// ============================================================================
module ex_operand_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_id_valid,
    input  logic [DW-1:0]   i_id_rs_val,
    input  logic [DW-1:0]   i_id_rt_val,
    input  logic [DW-1:0]   i_id_imm,
    input  logic [RW-1:0]   i_id_rs,
    input  logic [RW-1:0]   i_id_rt,
    input  logic [RW-1:0]   i_id_rd,
    input  logic            i_id_uses_rt,
    input  logic            i_id_alusrc,
    input  logic [3:0]      i_id_alu_sel,
    input  logic [4:0]      i_id_shamt,
    input  logic            i_id_regwrite,
    input  logic            i_id_memread,
    input  logic            i_id_memwrite,
    input  logic            i_id_memtoreg,
    input  logic            i_flush,
    input  logic            i_exmem_regwrite,
    input  logic [RW-1:0]   i_exmem_rd,
    input  logic [DW-1:0]   i_exmem_result,
    input  logic            i_memwb_regwrite,
    input  logic [RW-1:0]   i_memwb_rd,
    input  logic [DW-1:0]   i_memwb_result,
    output logic            o_stall,
    output logic [DW-1:0]   o_alu_a,
    output logic [DW-1:0]   o_alu_b,
    output logic [3:0]      o_alu_sel,
    output logic [4:0]      o_alu_shamt,
    output logic [DW-1:0]   o_ex_store_data,
    output logic [RW-1:0]   o_ex_rd,
    output logic            o_ex_valid,
    output logic            o_ex_regwrite,
    output logic            o_ex_memread,
    output logic            o_ex_memwrite,
    output logic            o_ex_memtoreg,
    output logic [CNTW-1:0] o_stall_count
);

    // ID/EX register contents
    logic            r_valid, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_alusrc;
    logic [DW-1:0]   r_rs_val, r_rt_val, r_imm;
    logic [RW-1:0]   r_rs, r_rt, r_rd;
    logic [3:0]      r_alu_sel;
    logic [4:0]      r_shamt;
    logic [CNTW-1:0] r_stall_count;

    logic            w_stall;
    logic [DW-1:0]   w_fwd_a, w_fwd_rt;

`ifdef EX_FWD_EN
    // Only a load that is still in EX cannot be forwarded in time.
    always_comb begin
        w_stall = i_id_valid & r_valid & r_memread & (r_rd != '0) &
                  ((r_rd == i_id_rs) | (i_id_uses_rt & (r_rd == i_id_rt)));
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    // Register 0 is never forwarded.
    always_comb begin
        w_fwd_a = r_rs_val;
        if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == r_rs))
            w_fwd_a = i_exmem_result;
        else if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == r_rs))
            w_fwd_a = i_memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_val;
        if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == r_rt))
            w_fwd_rt = i_exmem_result;
        else if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == r_rt))
            w_fwd_rt = i_memwb_result;
    end
`else
    logic w_ex_hit, w_mem_hit;
    logic w_unused_fwd;

    // Without forwarding, decode waits until the producer has passed EX and
    // EX/MEM. MEM/WB needs no stall because the register file writes on the
    // falling edge.
    always_comb begin
        w_ex_hit  = r_valid & r_regwrite & (r_rd != '0) &
                    ((r_rd == i_id_rs) | (i_id_uses_rt & (r_rd == i_id_rt)));
        w_mem_hit = i_exmem_regwrite & (i_exmem_rd != '0) &
                    ((i_exmem_rd == i_id_rs) | (i_id_uses_rt & (i_exmem_rd == i_id_rt)));
        w_stall   = i_id_valid & (w_ex_hit | w_mem_hit);
        w_fwd_a   = r_rs_val;
        w_fwd_rt  = r_rt_val;
    end

    assign w_unused_fwd = ^{i_exmem_result, i_memwb_regwrite, i_memwb_rd,
                            i_memwb_result, r_rs, r_rt};
`endif

    // A flush or a stall loads a bubble into the register. Only a stall that
    // is not flushed counts as a bubble cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid       <= 1'b0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_alusrc      <= 1'b0;
            r_rs_val      <= '0;
            r_rt_val      <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_alu_sel     <= 4'b0000;
            r_shamt       <= '0;
            r_stall_count <= '0;
        end else if (i_flush || w_stall) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs_val   <= '0;
            r_rt_val   <= '0;
            r_imm      <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_alu_sel  <= 4'b0000;
            r_shamt    <= '0;
            if (!i_flush && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end else begin
            r_valid    <= i_id_valid;
            r_regwrite <= i_id_valid & i_id_regwrite;
            r_memread  <= i_id_valid & i_id_memread;
            r_memwrite <= i_id_valid & i_id_memwrite;
            r_memtoreg <= i_id_valid & i_id_memtoreg;
            r_alusrc   <= i_id_alusrc;
            r_rs_val   <= i_id_rs_val;
            r_rt_val   <= i_id_rt_val;
            r_imm      <= i_id_imm;
            r_rs       <= i_id_rs;
            r_rt       <= i_id_rt;
            r_rd       <= i_id_rd;
            r_alu_sel  <= i_id_alu_sel;
            r_shamt    <= i_id_shamt;
        end
    end

    assign o_stall         = w_stall;
    assign o_alu_a         = w_fwd_a;
    assign o_alu_b         = r_alusrc ? r_imm : w_fwd_rt;
    assign o_ex_store_data = w_fwd_rt;
    assign o_alu_sel       = r_alu_sel;
    assign o_alu_shamt     = r_shamt;
    assign o_ex_rd         = r_rd;
    assign o_ex_valid      = r_valid;
    assign o_ex_regwrite   = r_regwrite;
    assign o_ex_memread    = r_memread;
    assign o_ex_memwrite   = r_memwrite;
    assign o_ex_memtoreg   = r_memtoreg;
    assign o_stall_count   = r_stall_count;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage. The stall counter is built narrow
// (3 bits) so that saturation can be reached in a few cycles.
module tb_ex_operand_stage;

    localparam int DW = 32, RW = 5, CNTW = 3;

    logic            clk = 1'b0, reset_n = 1'b0;
    logic            id_valid = 0, id_uses_rt = 0, id_alusrc = 0;
    logic [DW-1:0]   id_rs_val = 0, id_rt_val = 0, id_imm = 0;
    logic [RW-1:0]   id_rs = 0, id_rt = 0, id_rd = 0;
    logic [3:0]      id_alu_sel = 0;
    logic [4:0]      id_shamt = 0;
    logic            id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_memtoreg = 0;
    logic            flush = 0;
    logic            exmem_regwrite = 0, memwb_regwrite = 0;
    logic [RW-1:0]   exmem_rd = 0, memwb_rd = 0;
    logic [DW-1:0]   exmem_result = 0, memwb_result = 0;
    logic            stall;
    logic [DW-1:0]   alu_a, alu_b, store_data;
    logic [3:0]      alu_sel;
    logic [4:0]      alu_shamt;
    logic [RW-1:0]   ex_rd;
    logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [CNTW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_id_valid(id_valid),
        .i_id_rs_val(id_rs_val), .i_id_rt_val(id_rt_val), .i_id_imm(id_imm),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
        .i_id_uses_rt(id_uses_rt), .i_id_alusrc(id_alusrc),
        .i_id_alu_sel(id_alu_sel), .i_id_shamt(id_shamt),
        .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
        .i_id_memwrite(id_memwrite), .i_id_memtoreg(id_memtoreg),
        .i_flush(flush),
        .i_exmem_regwrite(exmem_regwrite), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_result),
        .i_memwb_regwrite(memwb_regwrite), .i_memwb_rd(memwb_rd), .i_memwb_result(memwb_result),
        .o_stall(stall), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
        .o_alu_shamt(alu_shamt), .o_ex_store_data(store_data), .o_ex_rd(ex_rd),
        .o_ex_valid(ex_valid), .o_ex_regwrite(ex_regwrite), .o_ex_memread(ex_memread),
        .o_ex_memwrite(ex_memwrite), .o_ex_memtoreg(ex_memtoreg), .o_stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Step past the next rising edge and let the registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic id_set(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic [DW-1:0] rsv,
                          input logic [DW-1:0] rtv);
        id_valid   = 1'b1;
        id_uses_rt = 1'b1;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_val  = rsv;
        id_rt_val  = rtv;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        settle();
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset alu_sel", 32'(alu_sel), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        check("reset ex_regwrite", 32'(ex_regwrite), 32'd0);

        // add $3,$1,$2
        id_set(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
        id_alu_sel = 4'h2; id_shamt = 5'd5; id_regwrite = 1'b1;
        settle();
        check("add no stall", 32'(stall), 32'd0);
        tick();
        check("add alu_a", alu_a, 32'h11);
        check("add alu_b", alu_b, 32'h22);
        check("add alu_sel", 32'(alu_sel), 32'h2);
        check("add shamt", 32'(alu_shamt), 32'd5);
        check("add ex_rd", 32'(ex_rd), 32'd3);
        check("add ex_valid", 32'(ex_valid), 32'd1);
        check("add store_data", store_data, 32'h22);

`ifdef EX_FWD_EN
        // sub $4,$3,$1 back-to-back: forwarded from EX/MEM, no stall
        id_set(5'd3, 5'd1, 5'd4, 32'h0, 32'h11);
        settle();
        check("sub no stall", 32'(stall), 32'd0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        settle();
        check("sub fwd alu_a", alu_a, 32'h10);
        check("sub alu_b", alu_b, 32'h11);

        // Both forward sources target $7: EX/MEM wins
        id_set(5'd7, 5'd0, 5'd8, 32'h0, 32'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'hAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 32'hBB;
        settle();
        check("prio exmem", alu_a, 32'hAA);
        exmem_regwrite = 1'b0;
        settle();
        check("prio memwb", alu_a, 32'hBB);

        // Writer to $0 is never forwarded
        memwb_regwrite = 1'b0;
        id_set(5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
        settle();
        check("zero no fwd", alu_a, 32'd0);
        exmem_regwrite = 1'b0;

        // lw $5 then add $6,$5,$5: one bubble, then forward from MEM/WB
        id_set(5'd1, 5'd0, 5'd5, 32'h11, 32'h0);
        id_uses_rt = 1'b0; id_memread = 1'b1; id_memtoreg = 1'b1;
        tick();
        id_set(5'd5, 5'd5, 5'd6, 32'h0, 32'h0);
        id_memread = 1'b0; id_memtoreg = 1'b0;
        settle();
        check("lu stall", 32'(stall), 32'd1);
        tick();
        check("lu bubble valid", 32'(ex_valid), 32'd0);
        check("lu stall_count", 32'(stall_count), 32'd1);
        check("lu stall cleared", 32'(stall), 32'd0);
        tick();
        memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h55;
        settle();
        check("lu alu_a", alu_a, 32'h55);
        check("lu alu_b", alu_b, 32'h55);
        memwb_regwrite = 1'b0;

        // flush during a load-use stall
        id_set(5'd1, 5'd0, 5'd8, 32'h0, 32'h0);
        id_uses_rt = 1'b0; id_memread = 1'b1;
        tick();
        id_set(5'd8, 5'd0, 5'd9, 32'h0, 32'h0);
        id_memread = 1'b0; flush = 1'b1;
        settle();
        check("flush stall driven", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        check("flush memread", 32'(ex_memread), 32'd0);
        check("flush regwrite", 32'(ex_regwrite), 32'd0);
        check("flush count kept", 32'(stall_count), 32'd1);
`else
        // add $4,$3,$3: stalls on EX, then on EX/MEM
        id_set(5'd3, 5'd3, 5'd4, 32'h0, 32'h0);
        settle();
        check("raw stall ex", 32'(stall), 32'd1);
        tick();
        check("bubble ex_valid", 32'(ex_valid), 32'd0);
        check("bubble regwrite", 32'(ex_regwrite), 32'd0);
        check("bubble alu_sel", 32'(alu_sel), 32'd0);
        check("bubble count 1", 32'(stall_count), 32'd1);
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h33;
        settle();
        check("raw stall exmem", 32'(stall), 32'd1);
        tick();
        check("bubble count 2", 32'(stall_count), 32'd2);
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h33;
        id_rs_val = 32'h33; id_rt_val = 32'h33;
        settle();
        check("raw clear", 32'(stall), 32'd0);
        tick();
        check("raw alu_a regfile", alu_a, 32'h33);
        check("raw alu_b regfile", alu_b, 32'h33);
        check("raw ex_rd", 32'(ex_rd), 32'd4);
        check("raw count kept", 32'(stall_count), 32'd2);

        // $0 source plus immediate operand
        memwb_regwrite = 1'b0;
        id_set(5'd0, 5'd0, 5'd6, 32'h0, 32'h0);
        id_alusrc = 1'b1; id_imm = 32'h1234;
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
        settle();
        check("zero no stall", 32'(stall), 32'd0);
        tick();
        check("zero alu_a", alu_a, 32'd0);
        check("imm alu_b", alu_b, 32'h1234);
        check("imm store_data", store_data, 32'd0);

        // id_valid=0 clears the write controls but still captures the fields
        exmem_regwrite = 1'b0; id_alusrc = 1'b0;
        id_set(5'd6, 5'd7, 5'd8, 32'h0, 32'h0);
        id_valid = 1'b0; id_alu_sel = 4'h9;
        settle();
        check("invalid no stall", 32'(stall), 32'd0);
        tick();
        check("invalid ex_valid", 32'(ex_valid), 32'd0);
        check("invalid regwrite", 32'(ex_regwrite), 32'd0);
        check("invalid alu_sel", 32'(alu_sel), 32'h9);

        // lw $5 then a dependent instruction with flush
        id_set(5'd1, 5'd0, 5'd5, 32'h0, 32'h0);
        id_uses_rt = 1'b0; id_memread = 1'b1; id_memtoreg = 1'b1; id_alu_sel = 4'h0;
        tick();
        check("lw memread", 32'(ex_memread), 32'd1);
        id_set(5'd5, 5'd5, 5'd6, 32'h0, 32'h0);
        id_memread = 1'b0; id_memtoreg = 1'b0; flush = 1'b1;
        settle();
        check("flush stall driven", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        check("flush memread", 32'(ex_memread), 32'd0);
        check("flush memtoreg", 32'(ex_memtoreg), 32'd0);
        check("flush count kept", 32'(stall_count), 32'd2);

        // Saturation: a held EX/MEM match stalls every cycle
        exmem_regwrite = 1'b1; exmem_rd = 5'd9;
        id_set(5'd9, 5'd0, 5'd10, 32'h0, 32'h0);
        repeat (5) tick();
        check("count at max", 32'(stall_count), 32'd7);
        tick();
        check("count saturated", 32'(stall_count), 32'd7);

        // Asynchronous reset mid-stall
        #2 reset_n = 1'b0;
        #1;
        check("async count", 32'(stall_count), 32'd0);
        check("async ex_valid", 32'(ex_valid), 32'd0);
        check("async alu_a", alu_a, 32'd0);
        check("async alu_sel", 32'(alu_sel), 32'd0);
        exmem_regwrite = 1'b0;
        #4 reset_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
